flag_register_unit: RTL and testbench

FLAG_REGISTER_UNIT -- requirements
Module: flag_register_unit

---
 rtl/flag_pkg.sv | 33 +++
 rtl/flag_shadow_stack.sv | 47 ++++
 rtl/flag_register_unit.sv | 114 +++++++++++
 tb/tb_flag_register_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared constants for the flag register unit.
// Flag bit positions and branch-condition encodings.
package flag_pkg;

  localparam int FLAG_W     = 5;
  localparam int NEST_DEPTH = 2;

  localparam int ZF = 0;
  localparam int SF = 1;
  localparam int CF = 2;

  typedef enum logic [1:0] {
    BR_JMP = 2'b00,
    BR_JZ  = 2'b01,
    BR_JN  = 2'b10,
    BR_JC  = 2'b11
  } br_cond_e;

  // Flag bit tested by a conditional branch.
  function automatic logic [1:0] cond_bit(
    input br_cond_e c
  );
    logic [1:0] b;
    b = 2'(ZF);
    case (c)
      BR_JN:   b = 2'(SF);
      BR_JC:   b = 2'(CF);
      default: b = 2'(ZF);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved flag vectors for nested interrupts.
// Caller qualifies push/pop; full/empty are guarded again here.
module flag_shadow_stack #(
  parameter int W     = 5,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  data,
  output logic [W-1:0]  top,
  output logic [PW-1:0] ptr,
  output logic          empty,
  output logic          full
);

  logic [W-1:0] mem [DEPTH];

  assign empty = (ptr == '0);
  assign full  = (ptr == PW'(DEPTH));

  // Entry addressed by ptr-1 is the top of the stack.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr == PW'(i + 1)) top = mem[i];
    end
  end

  // Pointer and storage update; reset wipes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !pop && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr == PW'(i)) mem[i] <= data;
      end
      ptr <= ptr + PW'(1);
    end else if (pop && !push && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

endmodule

// File: rtl/flag_register_unit.sv
// Flag register with branch resolve and interrupt shadow stack.
// Define FLAG_BYPASS_EN to resolve branches on same-cycle ALU flags.
module flag_register_unit #(
  parameter int FLAG_W     = flag_pkg::FLAG_W,
  parameter int NEST_DEPTH = flag_pkg::NEST_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] alu_flags_in,
  input  logic              flags_we,
  input  logic              br_valid,
  input  logic [1:0]        br_cond,
  input  logic              int_save,
  input  logic              int_restore,
  output logic [FLAG_W-1:0] flags_out,
  output logic              br_taken,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  import flag_pkg::*;

  localparam int PW = $clog2(NEST_DEPTH + 1);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] eff;
  logic [FLAG_W-1:0] eval;
  logic [FLAG_W-1:0] mask;
  logic [FLAG_W-1:0] top;
  logic [PW-1:0]     ptr;
  logic              empty;
  logic              full;
  logic              is_jmp;
  logic              sel;
  logic              clr;
  logic              do_push;
  logic              do_pop;
  logic              err_set;
  logic              err_q;

  assign eff = flags_we ? alu_flags_in : flags_q;

`ifdef FLAG_BYPASS_EN
  assign eval = eff;
`else
  assign eval = flags_q;
`endif

  assign is_jmp   = (br_cond_e'(br_cond) == BR_JMP);
  assign mask     = FLAG_W'(1) << cond_bit(br_cond_e'(br_cond));
  assign sel      = |(eval & mask);
  assign br_taken = br_valid & (is_jmp | sel);
  assign clr      = br_valid & ~is_jmp & sel;

  assign do_push = int_save & ~int_restore & ~full;
  assign do_pop  = int_restore & ~int_save & ~empty;
  assign err_set = (int_save & int_restore)
                 | (int_save & full)
                 | (int_restore & empty);

  // Next flags: restore first, then clear/write order by config.
  always_comb begin
    flags_d = flags_q;
    if (do_pop) begin
      flags_d = top;
`ifdef FLAG_BYPASS_EN
    end else if (clr) begin
      flags_d = eval & ~mask;
    end else if (flags_we) begin
      flags_d = alu_flags_in;
`else
    end else if (flags_we) begin
      flags_d = alu_flags_in;
    end else if (clr) begin
      flags_d = eval & ~mask;
`endif
    end
  end

  // Flag register and sticky stack protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  flag_shadow_stack #(
    .W     (FLAG_W),
    .DEPTH (NEST_DEPTH),
    .PW    (PW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .data  (eff),
    .top   (top),
    .ptr   (ptr),
    .empty (empty),
    .full  (full)
  );

  assign flags_out   = flags_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: queue-based model plus directed vectors.
// Follows FLAG_BYPASS_EN the same way the design does.
module tb_flag_register_unit;

  localparam int FW = 5;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] alu;
  logic          flags_we;
  logic          br_valid;
  logic [1:0]    br_cond;
  logic          int_save;
  logic          int_restore;
  logic [FW-1:0] flags_out;
  logic          br_taken;
  logic          stack_empty;
  logic          stack_full;
  logic          stack_err;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  flag_register_unit #(
    .FLAG_W     (FW),
    .NEST_DEPTH (ND)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_flags_in (alu),
    .flags_we     (flags_we),
    .br_valid     (br_valid),
    .br_cond      (br_cond),
    .int_save     (int_save),
    .int_restore  (int_restore),
    .flags_out    (flags_out),
    .br_taken     (br_taken),
    .stack_empty  (stack_empty),
    .stack_full   (stack_full),
    .stack_err    (stack_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: architectural flags, saved-flags queue, error bit.
  logic [FW-1:0] m_flags;
  logic [FW-1:0] m_stk[$];
  logic          m_err;

  function automatic logic [FW-1:0] m_src();
    if (BYP && flags_we) return alu;
    return m_flags;
  endfunction

  function automatic logic m_br();
    logic [FW-1:0] s;
    if (!br_valid) return 1'b0;
    if (br_cond == 2'b00) return 1'b1;
    s = m_src();
    return s[int'(br_cond) - 1];
  endfunction

  logic [FW-1:0] nf;
  logic [FW-1:0] pv;
  bit            popped;
  bit            tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags = '0;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      tk     = m_br() && br_cond != 2'b00;
      popped = 1'b0;
      pv     = '0;
      if (int_save && int_restore) begin
        m_err = 1'b1;
      end else if (int_save) begin
        if (m_stk.size() == ND) m_err = 1'b1;
        else m_stk.push_back(flags_we ? alu : m_flags);
      end else if (int_restore) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin
          pv     = m_stk.pop_back();
          popped = 1'b1;
        end
      end
      nf = m_flags;
      if (BYP) begin
        if (tk) begin
          nf = m_src();
          nf[int'(br_cond) - 1] = 1'b0;
        end else if (flags_we) nf = alu;
      end else begin
        if (flags_we) nf = alu;
        else if (tk) nf[int'(br_cond) - 1] = 1'b0;
      end
      if (popped) nf = pv;
      m_flags = nf;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_flags_out", flags_out, m_flags);
    chk("m_empty", stack_empty, m_stk.size() == 0);
    chk("m_full", stack_full, m_stk.size() == ND);
    chk("m_err", stack_err, m_err);
    chk("m_br_taken", br_taken, m_br());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flags_we    = 1'b0;
    alu         = '0;
    br_valid    = 1'b0;
    br_cond     = 2'b00;
    int_save    = 1'b0;
    int_restore = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_flags", flags_out, 5'b00000);
    chk("rst_empty", stack_empty, 1'b1);
    chk("rst_full", stack_full, 1'b0);
    chk("rst_err", stack_err, 1'b0);
    br_valid = 1'b1; br_cond = 2'b01; #1;
    chk("rst_jz", br_taken, 1'b0);
    br_cond = 2'b00; #1;
    chk("rst_jmp", br_taken, 1'b1);
    idle();
    cyc();
    rst_n = 1'b1;

    // Same-cycle JZ on freshly written zero flag
    flags_we = 1; alu = 5'b00001; br_valid = 1; br_cond = 2'b01; #1;
    chk("bypass_taken", br_taken, BYP ? 1'b1 : 1'b0);
    cyc(); idle();
    chk("bypass_flags", flags_out, BYP ? 5'b00000 : 5'b00001);

    // JC clears carry, then falls through
    flags_we = 1; alu = 5'b00100; cyc(); idle();
    chk("jc_pre", flags_out, 5'b00100);
    br_valid = 1; br_cond = 2'b11; #1;
    chk("jc_taken", br_taken, 1'b1);
    cyc();
    chk("jc_cleared", flags_out, 5'b00000);
    chk("jc_again", br_taken, 1'b0);
    cyc(); idle();

    // JN clear leaves reserved bits alone
    flags_we = 1; alu = 5'b11110; cyc(); idle();
    br_valid = 1; br_cond = 2'b10; #1;
    chk("jn_taken", br_taken, 1'b1);
    cyc(); idle();
    chk("jn_cleared", flags_out, 5'b11100);
    br_valid = 1; br_cond = 2'b01; #1;
    chk("jz_not", br_taken, 1'b0);
    cyc(); idle();
    chk("jz_hold", flags_out, 5'b11100);

    // Save, overwrite, restore
    flags_we = 1; alu = 5'b00010; cyc(); idle();
    int_save = 1; cyc(); idle();
    chk("save_nonempty", stack_empty, 1'b0);
    flags_we = 1; alu = 5'b00101; cyc(); idle();
    chk("isr_write", flags_out, 5'b00101);
    int_restore = 1; flags_we = 1; alu = 5'b11000; cyc(); idle();
    chk("restore_val", flags_out, 5'b00010);
    chk("restore_empty", stack_empty, 1'b1);
    chk("restore_noerr", stack_err, 1'b0);

    // Restore on empty stack
    int_restore = 1; cyc(); idle();
    chk("underflow_err", stack_err, 1'b1);
    chk("underflow_flags", flags_out, 5'b00010);

    // Reset in the middle of a push
    flags_we = 1; alu = 5'b00111; cyc(); idle();
    chk("pre_rst", flags_out, 5'b00111);
    int_save = 1; #2;
    rst_n = 1'b0; #1;
    chk("async_flags", flags_out, 5'b00000);
    chk("async_empty", stack_empty, 1'b1);
    chk("async_err", stack_err, 1'b0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("no_partial", stack_empty, 1'b1);

    // Fill, overflow, LIFO unwind
    flags_we = 1; alu = 5'b01001; int_save = 1; cyc();
    flags_we = 1; alu = 5'b10100; int_save = 1; cyc(); idle();
    chk("fill_full", stack_full, 1'b1);
    chk("fill_noerr", stack_err, 1'b0);
    int_save = 1; cyc(); idle();
    chk("ovf_full", stack_full, 1'b1);
    chk("ovf_err", stack_err, 1'b1);
    chk("ovf_flags", flags_out, 5'b10100);
    flags_we = 1; alu = 5'b00000; cyc(); idle();
    int_restore = 1; flags_we = 1; alu = 5'b00011; cyc(); idle();
    chk("pop1", flags_out, 5'b10100);
    chk("pop1_full", stack_full, 1'b0);
    int_restore = 1; cyc(); idle();
    chk("pop2", flags_out, 5'b01001);
    chk("pop2_empty", stack_empty, 1'b1);

    // Simultaneous save and restore
    #2; rst_n = 1'b0; #1;
    cyc();
    rst_n = 1'b1;
    flags_we = 1; alu = 5'b00110; int_save = 1; cyc(); idle();
    int_save = 1; int_restore = 1; flags_we = 1; alu = 5'b00011;
    cyc(); idle();
    chk("both_empty", stack_empty, 1'b0);
    chk("both_full", stack_full, 1'b0);
    chk("both_err", stack_err, 1'b1);
    chk("both_flags", flags_out, 5'b00011);
    int_restore = 1; cyc(); idle();
    chk("both_pop", flags_out, 5'b00110);
    chk("both_pop_empty", stack_empty, 1'b1);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
